// File: rtl/shift_right_pipe_32_pkg.sv
// Shared ALU shift definitions: operation encodings, datapath widths and
// the fill-bit helper used at the head of the right-shift pipeline.
package shift_right_pipe_32_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic SHIFT_SRL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

    // Bit shifted into vacated MSBs; computed once from the unshifted operand.
    function automatic logic fill_bit(input logic arith, input logic msb);
        return (arith == SHIFT_SRA) & msb;
    endfunction

endpackage

// File: rtl/shift_right_pipe_32_stage.sv
// One pipeline stage of the right shifter: conditional shift by STEP on the
// way into the register, plus valid/data/tag holding and local advance.
module shift_right_stage
    import shift_right_pipe_32_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int TAG_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               up_valid,
    input  logic [DATA_W-1:0]  up_data,
    input  logic [SHAMT_W-1:0] up_shamt,
    input  logic               up_fill,
    input  logic [TAG_W-1:0]   up_tag,
    input  logic               down_adv,
    output logic               adv,
    output logic               valid,
    output logic [DATA_W-1:0]  data,
    output logic [SHAMT_W-1:0] shamt,
    output logic               fill,
    output logic [TAG_W-1:0]   tag
);

    localparam int BIT = $clog2(STEP);

    logic               valid_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [SHAMT_W-1:0] shamt_reg;
    logic               fill_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [DATA_W-1:0]  shifted;

    always_comb begin
        shifted = up_data;
        if (up_shamt[BIT]) begin
            shifted = {{STEP{up_fill}}, up_data[DATA_W-1:STEP]};
        end
    end

    // Register may load when it is empty or its content moves on this cycle.
    assign adv = down_adv | ~valid_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            shamt_reg <= '0;
            fill_reg  <= 1'b0;
            tag_reg   <= '0;
        end else if (adv) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg  <= shifted;
                shamt_reg <= up_shamt;
                fill_reg  <= up_fill;
                tag_reg   <= up_tag;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign shamt = shamt_reg;
    assign fill  = fill_reg;
    assign tag   = tag_reg;

endmodule

// File: rtl/shift_right_pipe_32.sv
// Five-stage pipelined 32-bit logical/arithmetic right shifter with
// valid/ready handshakes and a sideband tag carried in order with each result.
module shift_right_pipe_32
    import shift_right_pipe_32_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag
);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic               valid_chain [0:SHAMT_W];
    logic [DATA_W-1:0]  data_chain  [0:SHAMT_W];
    logic [SHAMT_W-1:0] shamt_chain [0:SHAMT_W];
    logic               fill_chain  [0:SHAMT_W];
    logic [TAG_W-1:0]   tag_chain   [0:SHAMT_W];
    logic               adv_chain   [0:SHAMT_W-1];
    logic [SHAMT_W-1:0] down_adv;

    assign valid_chain[0] = in_valid;
    assign data_chain[0]  = in_data;
    assign shamt_chain[0] = in_shamt;
    assign fill_chain[0]  = fill_bit(in_arith, in_data[DATA_W-1]);
    assign tag_chain[0]   = in_tag;

    // Downstream readiness derived from valid bits alone, so the advance
    // chain is a flat OR-reduction rather than a stage-to-stage loop.
    always_comb begin
        down_adv = '0;
        down_adv[SHAMT_W-1] = out_ready;
        for (int k = SHAMT_W - 2; k >= 0; k--) begin
            down_adv[k] = down_adv[k+1] | ~valid_chain[k+2];
        end
    end

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            shift_right_stage #(
                .STEP  (1 << gi),
                .TAG_W (TAG_W)
            ) u_stage (
                .clock    (clock),
                .reset_n  (reset_n),
                .up_valid (valid_chain[gi]),
                .up_data  (data_chain[gi]),
                .up_shamt (shamt_chain[gi]),
                .up_fill  (fill_chain[gi]),
                .up_tag   (tag_chain[gi]),
                .down_adv (down_adv[gi]),
                .adv      (adv_chain[gi]),
                .valid    (valid_chain[gi+1]),
                .data     (data_chain[gi+1]),
                .shamt    (shamt_chain[gi+1]),
                .fill     (fill_chain[gi+1]),
                .tag      (tag_chain[gi+1])
            );
        end
    endgenerate

    assign in_ready  = adv_chain[0] & reset_n;
    assign out_valid = valid_chain[SHAMT_W];
    assign out_data  = data_chain[SHAMT_W];
    assign out_tag   = tag_chain[SHAMT_W];

endmodule

// File: tb/tb_shift_right_pipe_32.sv
// Self-checking bench for shift_right_pipe_32: vector table, scoreboard queue,
// stall/streaming/reset sequences and a randomized sweep with backpressure.
module tb_shift_right_pipe_32;

    localparam int TAG_W = 5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic [4:0]        in_shamt = '0;
    logic              in_arith = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic [TAG_W-1:0]  out_tag;

    shift_right_pipe_32 #(.TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0]      data;
        logic [4:0]       shamt;
        logic             arith;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sent_cyc = 0;
    int          out_seen = 0;
    logic [31:0] cur_exp = '0;
    exp_t        sb[$];
    vec_t        vecs[14];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a) return $unsigned($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: both transfers take effect at the next rising edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h/%0d required=none", out_data, out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_data", out_data, e.data);
                    check("result_tag", 32'(out_tag), 32'(e.tag));
                    out_seen++;
                end
            end
            if (in_valid && in_ready) sb.push_back('{cur_exp, in_tag});
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [TAG_W-1:0] t, input logic [31:0] e);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_arith = a; in_tag = t; cur_exp = e;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready 0 required=1");
        end
        sent_cyc = cyc;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Returns at a negedge where out_valid is high, or after the budget.
    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clock);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            n++;
            @(posedge clock); #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int sent;
        int guard;
        int seen0;
        logic took;

        vecs[0]  = '{32'h80000000, 5'd31, 1'b1, 5'd3,  32'hFFFFFFFF};
        vecs[1]  = '{32'h80000000, 5'd31, 1'b0, 5'd4,  32'h00000001};
        vecs[2]  = '{32'hF0F0F0F0, 5'd4,  1'b1, 5'd5,  32'hFF0F0F0F};
        vecs[3]  = '{32'h12345678, 5'd0,  1'b0, 5'd6,  32'h12345678};
        vecs[4]  = '{32'h87654321, 5'd0,  1'b1, 5'd7,  32'h87654321};
        vecs[5]  = '{32'h7FFFFFFF, 5'd31, 1'b1, 5'd8,  32'h00000000};
        vecs[6]  = '{32'h80000001, 5'd1,  1'b1, 5'd9,  32'hC0000000};
        vecs[7]  = '{32'hDEADBEEF, 5'd16, 1'b0, 5'd10, 32'h0000DEAD};
        vecs[8]  = '{32'hDEADBEEF, 5'd16, 1'b1, 5'd11, 32'hFFFFDEAD};
        vecs[9]  = '{32'h12345678, 5'd8,  1'b1, 5'd12, 32'h00123456};
        vecs[10] = '{32'hFFFFFFFF, 5'd31, 1'b0, 5'd13, 32'h00000001};
        vecs[11] = '{32'h80000000, 5'd15, 1'b1, 5'd14, 32'hFFFF0000};
        vecs[12] = '{32'hA5A5A5A5, 5'd3,  1'b0, 5'd15, 32'h14B4B4B4};
        vecs[13] = '{32'hA5A5A5A5, 5'd3,  1'b1, 5'd16, 32'hF4B4B4B4};

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;

        // Single SRA by 31: latency of exactly 5 cycles
        send(vecs[0].data, vecs[0].shamt, vecs[0].arith, vecs[0].tag, vecs[0].exp);
        wait_out();
        check("latency", 32'(cyc - sent_cyc), 32'd5);
        @(posedge clock); #1;
        drain();

        // Back-to-back operands emerge on consecutive cycles
        for (int i = 1; i <= 3; i++)
            send(vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].tag, vecs[i].exp);
        wait_out();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("consecutive_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clock); #1;
        drain();

        // Remaining table vectors streamed
        for (int i = 4; i < 14; i++)
            send(vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].tag, vecs[i].exp);
        drain();

        // Stall: only 5 of 7 accepted, contents hold
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data = $urandom; in_shamt = 5'($urandom); in_arith = 1'($urandom);
            in_tag = TAG_W'(i + 20);
            cur_exp = model(in_data, in_shamt, in_arith);
            @(negedge clock);
            if (in_ready) acc++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("stall_accepted", 32'(acc), 32'd5);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (8) @(posedge clock);
        #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, sb[0].data);
        check("hold_tag", 32'(out_tag), 32'(sb[0].tag));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        drain();

        // Full pipe streaming: push and pop every cycle
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom; in_shamt = 5'($urandom); in_arith = 1'($urandom);
            send(in_data, in_shamt, in_arith, TAG_W'(i), model(in_data, in_shamt, in_arith));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data = $urandom; in_shamt = 5'($urandom); in_arith = 1'($urandom);
            in_tag = TAG_W'(i + 8);
            cur_exp = model(in_data, in_shamt, in_arith);
            @(negedge clock);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            @(posedge clock); #1;
            check("stream_occupancy", 32'(sb.size()), 32'd5);
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-flight discards everything
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'hCAFE0000 + 32'(i), 5'(i), 1'b0, TAG_W'(i + 1), model(32'hCAFE0000 + 32'(i), 5'(i), 1'b0));
        wait_out();
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clock); #2 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clock); #1;
        send(32'h0000F00D, 5'd4, 1'b0, 5'd31, 32'h00000F00);
        wait_out();
        check("post_rst_latency", 32'(cyc - sent_cyc), 32'd5);
        @(negedge clock);
        check("single_result", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        drain();

        // Randomized sweep with random valid and backpressure
        seen0 = out_seen;
        sent = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            if (!in_valid && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_data = $urandom; in_shamt = 5'($urandom); in_arith = 1'($urandom);
                in_tag = TAG_W'($urandom);
                cur_exp = model(in_data, in_shamt, in_arith);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            took = in_valid && in_ready;
            @(posedge clock); #1;
            if (took) begin
                in_valid = 1'b0;
                sent++;
            end
            guard++;
        end
        in_valid = 1'b0;
        drain();
        check("sweep_sent", 32'(sent), 32'd10000);
        check("sweep_received", 32'(out_seen - seen0), 32'd10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
